// File: rtl/dc_bu_write_if.sv
// Pixel-in / line-buffer-write bundle between the pixel source, the write manager and the line buffers.
// master = write manager side, slave = source/buffer side.
interface dc_bu_write_if #(
    parameter int BUFF_ADDR_WIDTH = 7,
    parameter int BUFFER_NUM      = 5
);
    logic                       pixel_valid;
    logic                       end_of_line;
    logic                       pixel_ready;
    logic [BUFF_ADDR_WIDTH-1:0] mem_addr;
    logic [BUFFER_NUM-1:0]      we_vec;
    logic [BUFFER_NUM-1:0]      write_buffer_id;

    modport master (
        input  pixel_valid,
        input  end_of_line,
        output pixel_ready,
        output mem_addr,
        output we_vec,
        output write_buffer_id
    );

    modport slave (
        output pixel_valid,
        output end_of_line,
        input  pixel_ready,
        input  mem_addr,
        input  we_vec,
        input  write_buffer_id
    );
endinterface

// File: rtl/dc_bu_write_manager.sv
// Write-side address generator and line-buffer rotation with occupancy tracking.
// we_vec is same-cycle combinational; pixel_ready drops while every buffer holds an unconsumed line.
module dc_bu_write_manager #(
    parameter int BUFF_ADDR_WIDTH       = 7,
    parameter int BUFFER_SIZE           = 128,
    parameter int BUFFER_NUM            = 5,
    parameter int PIXELS_PER_LINE_WIDTH = 11
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic                             en,
    input  logic [PIXELS_PER_LINE_WIDTH-1:0] pixels_per_line,
    input  logic                             frame_start,
    input  logic                             line_consumed,
    output logic [2:0]                       lines_filled,
    output logic                             line_committed,
    output logic                             overflow,
    dc_bu_write_if.master                    wr
);

    localparam int ADDR_W = BUFF_ADDR_WIDTH + 1;
    localparam int CMP_W  = ((ADDR_W > PIXELS_PER_LINE_WIDTH) ? ADDR_W : PIXELS_PER_LINE_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT_FREE
    } state_t;

    state_t                state, state_nxt;
    // One extra bit so a full buffer parks at BUFFER_SIZE (out of range) instead of wrapping to 0.
    logic [ADDR_W-1:0]     addr, addr_nxt;
    logic [BUFFER_NUM-1:0] wbid, wbid_nxt;
    logic [2:0]            filled_nxt;
    logic                  committed_nxt;
    logic                  ovf_nxt;

    logic                  accept;
    logic                  commit;
    logic                  consume;
    logic                  in_range;
    logic [CMP_W-1:0]      addr_ext;
    logic [CMP_W-1:0]      ppl_ext;
    logic [CMP_W-1:0]      last_ext;

    assign addr_ext = CMP_W'(addr);
    assign ppl_ext  = CMP_W'(pixels_per_line);
    assign last_ext = CMP_W'(BUFFER_SIZE - 1);

    assign accept   = en && (state == WRITE) && wr.pixel_valid;
    assign commit   = en && (state == WRITE) && wr.end_of_line;
    assign consume  = en && line_consumed && (state != IDLE) && (lines_filled != 3'd0);
    assign in_range = (addr_ext <= ppl_ext) && (addr_ext <= last_ext);

    assign wr.pixel_ready     = en && (state == WRITE);
    assign wr.we_vec          = (accept && in_range) ? wbid : '0;
    assign wr.mem_addr        = addr[BUFF_ADDR_WIDTH-1:0];
    assign wr.write_buffer_id = wbid;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state          <= IDLE;
            addr           <= '0;
            wbid           <= BUFFER_NUM'(1);
            lines_filled   <= 3'd0;
            line_committed <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            state          <= state_nxt;
            addr           <= addr_nxt;
            wbid           <= wbid_nxt;
            lines_filled   <= filled_nxt;
            line_committed <= committed_nxt;
            overflow       <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        wbid_nxt      = wbid;
        filled_nxt    = lines_filled;
        committed_nxt = 1'b0;
        ovf_nxt       = overflow;

        if (accept && in_range) begin
            addr_nxt = addr + ADDR_W'(1);
        end
        if (accept && !in_range) begin
            ovf_nxt = 1'b1;
        end

        // A commit and a release in the same cycle cancel out.
        if (commit && !consume) begin
            filled_nxt = lines_filled + 3'd1;
        end else if (consume && !commit) begin
            filled_nxt = lines_filled - 3'd1;
        end

        if (commit) begin
            addr_nxt      = '0;
            wbid_nxt      = {wbid[BUFFER_NUM-2:0], wbid[BUFFER_NUM-1]};
            committed_nxt = 1'b1;
        end

        case (state)
            WRITE: begin
                if (commit && (filled_nxt == 3'(BUFFER_NUM))) begin
                    state_nxt = WAIT_FREE;
                end
            end
            WAIT_FREE: begin
                if (consume) begin
                    state_nxt = WRITE;
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase

        if (en && frame_start) begin
            state_nxt     = WRITE;
            addr_nxt      = '0;
            wbid_nxt      = BUFFER_NUM'(1);
            filled_nxt    = 3'd0;
            committed_nxt = 1'b0;
            ovf_nxt       = 1'b0;
        end

        if (!en) begin
            state_nxt     = state;
            addr_nxt      = addr;
            wbid_nxt      = wbid;
            filled_nxt    = lines_filled;
            committed_nxt = line_committed;
            ovf_nxt       = overflow;
        end
    end

endmodule

// File: tb/tb_dc_bu_write_manager.sv
// Directed scenarios plus randomized traffic, all checked every cycle against a line-level reference model.
module tb_dc_bu_write_manager;

    localparam int BAW  = 7;
    localparam int BSZ  = 128;
    localparam int BN   = 5;
    localparam int PPLW = 11;

    logic            clk = 1'b0;
    logic            nrst;
    logic            en;
    logic [PPLW-1:0] pixels_per_line;
    logic            frame_start;
    logic            line_consumed;
    logic [2:0]      lines_filled;
    logic            line_committed;
    logic            overflow;

    dc_bu_write_if #(.BUFF_ADDR_WIDTH(BAW), .BUFFER_NUM(BN)) bus ();

    dc_bu_write_manager #(
        .BUFF_ADDR_WIDTH      (BAW),
        .BUFFER_SIZE          (BSZ),
        .BUFFER_NUM           (BN),
        .PIXELS_PER_LINE_WIDTH(PPLW)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .en             (en),
        .pixels_per_line(pixels_per_line),
        .frame_start    (frame_start),
        .line_consumed  (line_consumed),
        .lines_filled   (lines_filled),
        .line_committed (line_committed),
        .overflow       (overflow),
        .wr             (bus.master)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: frame started?, write position, buffer index, filled lines, pulses.
    int m_started = 0;
    int m_addr    = 0;
    int m_buf     = 0;
    int m_filled  = 0;
    int m_pulse   = 0;
    int m_ovf     = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_addr    = 0;
        m_buf     = 0;
        m_filled  = 0;
        m_pulse   = 0;
        m_ovf     = 0;
    endtask

    // One clock: drive at negedge, check outputs, advance model at posedge.
    task automatic step(input bit r, input bit e, input bit f, input bit v, input bit l, input bit c);
        int rdy;
        int inr;
        int wr_ok;
        int cmt;
        int cns;
        nrst            = r;
        en              = e;
        frame_start     = f;
        bus.pixel_valid = v;
        bus.end_of_line = l;
        line_consumed   = c;
        #1;
        rdy   = (e && m_started != 0 && m_filled < BN) ? 1 : 0;
        inr   = (m_addr <= int'(pixels_per_line) && m_addr < BSZ) ? 1 : 0;
        wr_ok = (rdy != 0 && v && inr != 0) ? 1 : 0;
        check_val("pixel_ready", 32'(bus.pixel_ready), 32'(rdy));
        check_val("we_vec", 32'(bus.we_vec), (wr_ok != 0) ? (32'd1 << m_buf) : 32'd0);
        check_val("mem_addr", 32'(bus.mem_addr), 32'(m_addr % BSZ));
        check_val("write_buffer_id", 32'(bus.write_buffer_id), 32'd1 << m_buf);
        check_val("lines_filled", 32'(lines_filled), 32'(m_filled));
        check_val("line_committed", 32'(line_committed), 32'(m_pulse));
        check_val("overflow", 32'(overflow), 32'(m_ovf));
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else if (e && f) begin
            m_started = 1;
            m_addr    = 0;
            m_buf     = 0;
            m_filled  = 0;
            m_pulse   = 0;
            m_ovf     = 0;
        end else if (e) begin
            cmt = (rdy != 0 && l) ? 1 : 0;
            cns = (c && m_started != 0 && m_filled > 0) ? 1 : 0;
            if (rdy != 0 && v && inr == 0) m_ovf = 1;
            if (cmt != 0) begin
                m_addr = 0;
                m_buf  = (m_buf + 1) % BN;
            end else if (wr_ok != 0) begin
                m_addr = m_addr + 1;
            end
            m_filled = m_filled + cmt - cns;
            m_pulse  = cmt;
        end
        @(negedge clk);
    endtask

    initial begin
        nrst            = 1'b0;
        en              = 1'b0;
        frame_start     = 1'b0;
        line_consumed   = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.end_of_line = 1'b0;
        pixels_per_line = PPLW'(3);
        @(negedge clk);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 1, 1);
        step(1, 1, 0, 1, 1, 1);

        // First line: four pixels, last one carries end_of_line.
        step(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, i == 3, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);

        // Fill every buffer, stall, then release one line.
        repeat (4) step(1, 1, 0, 0, 1, 0);
        repeat (2) step(1, 1, 0, 1, 1, 0);
        step(1, 1, 0, 1, 0, 1);
        step(1, 1, 0, 1, 0, 0);

        // Out-of-range pixels set a sticky overflow.
        pixels_per_line = PPLW'(2);
        step(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 1, 0);
        repeat (2) step(1, 1, 0, 0, 0, 0);

        // Commit and release together at four filled lines.
        step(1, 1, 1, 0, 0, 0);
        repeat (4) step(1, 1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1, 1);
        step(1, 1, 0, 1, 0, 0);

        // frame_start mid-line.
        pixels_per_line = PPLW'(10);
        step(1, 1, 1, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0, 1, 0);
        repeat (2) step(1, 1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 1, 1);
        step(1, 1, 0, 0, 0, 0);

        // Reset mid-line.
        repeat (2) step(1, 1, 0, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        step(1, 1, 0, 1, 1, 0);

        // Enable low freezes everything.
        step(1, 1, 1, 0, 0, 0);
        repeat (2) step(1, 1, 0, 1, 0, 0);
        repeat (3) step(1, 0, 1, 1, 1, 1);
        step(1, 1, 0, 1, 0, 0);

        // Line longer than a buffer.
        pixels_per_line = PPLW'(200);
        step(1, 1, 1, 0, 0, 0);
        repeat (131) step(1, 1, 0, 1, 0, 0);
        step(1, 1, 0, 1, 1, 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            bit r, e, f, v, l, c;
            r = ($urandom_range(0, 399) != 0);
            e = ($urandom_range(0, 9) != 0);
            f = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 99) < 15);
            if (f) pixels_per_line = PPLW'($urandom_range(0, 140));
            step(r, e, f, v, l, c);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
